// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-master to NUM_SLAVES interconnect: address decode, data-phase
// response mux and a built-in default slave. Optional stall watchdog under AHB_TIMEOUT_EN.

module ahb_slave_match #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] mask,
  output logic                  hit
);
  assign hit = (addr & mask) == base;
endmodule

module ahb_lite_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = {NUM_SLAVES{32'hFFFF_F000}},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            m_haddr_in,
  input  logic [DATA_WIDTH-1:0]            m_hwdata_in,
  input  logic [1:0]                       m_htrans_in,
  input  logic [2:0]                       m_hsize_in,
  input  logic [2:0]                       m_hburst_in,
  input  logic [3:0]                       m_hprot_in,
  input  logic                             m_hwrite_in,
  input  logic                             m_hmastlock_in,
  output logic [DATA_WIDTH-1:0]            m_hrdata_out,
  output logic                             m_hready_out,
  output logic                             m_hresp_out,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_haddr_out,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hwdata_out,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata_in,
  output logic [NUM_SLAVES*2-1:0]          s_htrans_out,
  output logic [NUM_SLAVES*3-1:0]          s_hsize_out,
  output logic [NUM_SLAVES*3-1:0]          s_hburst_out,
  output logic [NUM_SLAVES*4-1:0]          s_hprot_out,
  output logic [NUM_SLAVES-1:0]            s_hwrite_out,
  output logic [NUM_SLAVES-1:0]            s_hmastlock_out,
  output logic [NUM_SLAVES-1:0]            s_hsel_out,
  output logic [NUM_SLAVES-1:0]            s_hready_out,
  input  logic [NUM_SLAVES-1:0]            s_hready_in,
  input  logic [NUM_SLAVES-1:0]            s_hresp_in,
  output logic                             timeout_flag
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  ds_state_t             ds_state, ds_next;
  logic [NUM_SLAVES-1:0] raw_hit, hsel;
  logic [IDX_W-1:0]      hit_idx, dsel_idx;
  logic                  hit, xfer, miss_acc, timeout;
  logic                  dsel_slave;
  logic                  sel_ready, sel_resp;
  logic [DATA_WIDTH-1:0] sel_rdata;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
    ahb_slave_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .addr (m_haddr_in),
      .base (SLAVE_BASE_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .mask (SLAVE_ADDR_MASK[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .hit  (raw_hit[g])
    );
    assign s_htrans_out[g*2 +: 2] = hsel[g] ? m_htrans_in : 2'b00;
  end

  // Descending scan so the lowest matching index is the last writer.
  always_comb begin
    hsel    = '0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (raw_hit[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit      = |raw_hit;
  assign xfer     = m_htrans_in[1];
  assign miss_acc = m_hready_out && xfer && !hit;

  assign s_hsel_out      = hsel;
  assign s_haddr_out     = {NUM_SLAVES{m_haddr_in}};
  assign s_hwdata_out    = {NUM_SLAVES{m_hwdata_in}};
  assign s_hsize_out     = {NUM_SLAVES{m_hsize_in}};
  assign s_hburst_out    = {NUM_SLAVES{m_hburst_in}};
  assign s_hprot_out     = {NUM_SLAVES{m_hprot_in}};
  assign s_hwrite_out    = {NUM_SLAVES{m_hwrite_in}};
  assign s_hmastlock_out = {NUM_SLAVES{m_hmastlock_in}};
  assign s_hready_out    = {NUM_SLAVES{m_hready_out}};

  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_idx == IDX_W'(i)) begin
        sel_ready = s_hready_in[i];
        sel_resp  = s_hresp_in[i];
        sel_rdata = s_hrdata_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Error states own the response; dsel is NONE while they run.
  always_comb begin
    m_hready_out = 1'b1;
    m_hresp_out  = 1'b0;
    m_hrdata_out = '0;
    case (ds_state)
      DS_ERR1: begin
        m_hready_out = 1'b0;
        m_hresp_out  = 1'b1;
      end
      DS_ERR2: m_hresp_out = 1'b1;
      default: if (dsel_slave) begin
        m_hready_out = sel_ready;
        m_hresp_out  = sel_resp;
        m_hrdata_out = sel_rdata;
      end
    endcase
  end

  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_IDLE: if (miss_acc || timeout) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = miss_acc ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_state   <= DS_IDLE;
      dsel_slave <= 1'b0;
      dsel_idx   <= '0;
    end else begin
      ds_state <= ds_next;
      if (timeout) begin
        dsel_slave <= 1'b0;
      end else if (m_hready_out) begin
        dsel_slave <= xfer && hit;
        dsel_idx   <= hit_idx;
      end
    end
  end

`ifdef AHB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_flag;
  logic        stall;

  assign stall        = (ds_state == DS_IDLE) && dsel_slave && !sel_ready;
  assign timeout      = stall && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = to_flag;

  // Any ready or owner change drops stall, so clearing on !stall covers both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (timeout) to_flag <= 1'b1;
      if (!stall || timeout) to_cnt <= '0;
      else                   to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign timeout      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect: decode, wait states, default slave,
// BUSY handling, overlap priority, mid-transfer reset and the stall watchdog.
module tb_ahb_lite_interconnect;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]   haddr = '0;
  logic [DW-1:0]   hwdata = '0;
  logic [1:0]      htrans = 2'b00;
  logic [2:0]      hsize = 3'b010, hburst = 3'b000;
  logic [3:0]      hprot = 4'b0011;
  logic            hwrite = 1'b0, hmastlock = 1'b0;
  logic [DW-1:0]   hrdata;
  logic            hready, hresp;
  logic [N*AW-1:0] s_haddr;
  logic [N*DW-1:0] s_hwdata;
  logic [N*DW-1:0] s_hrdata = '0;
  logic [N*2-1:0]  s_htrans;
  logic [N*3-1:0]  s_hsize, s_hburst;
  logic [N*4-1:0]  s_hprot;
  logic [N-1:0]    s_hwrite, s_hmastlock, s_hsel, s_hready_o;
  logic [N-1:0]    s_hready_i = '1;
  logic [N-1:0]    s_hresp_i = '0;
  logic            tflag;

  logic [DW-1:0]   o2_hrdata;
  logic            o2_hready, o2_hresp, o2_tflag;
  logic [N*AW-1:0] o2_haddr;
  logic [N*DW-1:0] o2_hwdata;
  logic [N*2-1:0]  o2_htrans;
  logic [N*3-1:0]  o2_hsize, o2_hburst;
  logic [N*4-1:0]  o2_hprot;
  logic [N-1:0]    o2_hwrite, o2_hmastlock, o2_hsel, o2_hready_o;

  int checks = 0;
  int errors = 0;

  ahb_lite_interconnect dut (
    .clk(clk), .rst(rst),
    .m_haddr_in(haddr), .m_hwdata_in(hwdata), .m_htrans_in(htrans), .m_hsize_in(hsize),
    .m_hburst_in(hburst), .m_hprot_in(hprot), .m_hwrite_in(hwrite), .m_hmastlock_in(hmastlock),
    .m_hrdata_out(hrdata), .m_hready_out(hready), .m_hresp_out(hresp),
    .s_haddr_out(s_haddr), .s_hwdata_out(s_hwdata), .s_hrdata_in(s_hrdata),
    .s_htrans_out(s_htrans), .s_hsize_out(s_hsize), .s_hburst_out(s_hburst),
    .s_hprot_out(s_hprot), .s_hwrite_out(s_hwrite), .s_hmastlock_out(s_hmastlock),
    .s_hsel_out(s_hsel), .s_hready_out(s_hready_o), .s_hready_in(s_hready_i),
    .s_hresp_in(s_hresp_i), .timeout_flag(tflag)
  );

  // Overlapping map: slaves 1 and 2 both claim 0x1000.
  ahb_lite_interconnect #(
    .SLAVE_BASE_ADDR({32'h0000_3000, 32'h0000_1000, 32'h0000_1000, 32'h0000_0000})
  ) dut2 (
    .clk(clk), .rst(rst),
    .m_haddr_in(haddr), .m_hwdata_in(hwdata), .m_htrans_in(htrans), .m_hsize_in(hsize),
    .m_hburst_in(hburst), .m_hprot_in(hprot), .m_hwrite_in(hwrite), .m_hmastlock_in(hmastlock),
    .m_hrdata_out(o2_hrdata), .m_hready_out(o2_hready), .m_hresp_out(o2_hresp),
    .s_haddr_out(o2_haddr), .s_hwdata_out(o2_hwdata), .s_hrdata_in(s_hrdata),
    .s_htrans_out(o2_htrans), .s_hsize_out(o2_hsize), .s_hburst_out(o2_hburst),
    .s_hprot_out(o2_hprot), .s_hwrite_out(o2_hwrite), .s_hmastlock_out(o2_hmastlock),
    .s_hsel_out(o2_hsel), .s_hready_out(o2_hready_o), .s_hready_in(s_hready_i),
    .s_hresp_in(s_hresp_i), .timeout_flag(o2_tflag)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    haddr = 32'h1000; htrans = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hready !== 1'b1) begin errors++; $display("FAIL reset_hready got=%b exp=1", hready); end
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
    checks++; if (tflag !== 1'b0) begin errors++; $display("FAIL reset_tflag got=%b exp=0", tflag); end
    htrans = 2'b00;
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_read();
    s_hrdata[1*DW +: DW] = 32'hDEAD_BEEF;
    haddr = 32'h1004; htrans = 2'b10; hwrite = 1'b0;
    #1;
    checks++; if (s_hsel !== 4'b0010) begin errors++; $display("FAIL read_hsel got=%b exp=0010", s_hsel); end
    checks++; if (s_htrans !== 8'h08) begin errors++; $display("FAIL read_htrans got=%h exp=08", s_htrans); end
    checks++; if (s_haddr[3*AW +: AW] !== 32'h1004) begin errors++; $display("FAIL read_bcast_addr got=%h exp=1004", s_haddr[3*AW +: AW]); end
    next_cycle();
    htrans = 2'b00;
    #1;
    checks++; if (hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data got=%h exp=deadbeef", hrdata); end
    checks++; if (hresp !== 1'b0 || hready !== 1'b1) begin errors++; $display("FAIL read_resp got=%b/%b exp=1/0", hready, hresp); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    haddr = 32'h0010; htrans = 2'b10; hwrite = 1'b1; hwdata = 32'h1234_5678;
    #1;
    checks++; if (s_hsel !== 4'b0001) begin errors++; $display("FAIL b2b_hsel0 got=%b exp=0001", s_hsel); end
    next_cycle();
    haddr = 32'h2020; hwrite = 1'b0; s_hready_i[0] = 1'b0;
    s_hrdata[2*DW +: DW] = 32'h2222_2222;
    #1;
    checks++; if (hready !== 1'b0) begin errors++; $display("FAIL b2b_wait1 got=%b exp=0", hready); end
    checks++; if (s_hready_o !== 4'b0000) begin errors++; $display("FAIL b2b_sready got=%b exp=0000", s_hready_o); end
    checks++; if (s_hsel !== 4'b0100) begin errors++; $display("FAIL b2b_hsel2 got=%b exp=0100", s_hsel); end
    next_cycle();
    checks++; if (hready !== 1'b0) begin errors++; $display("FAIL b2b_wait2 got=%b exp=0", hready); end
    next_cycle();
    s_hready_i[0] = 1'b1;
    #1;
    checks++; if (hready !== 1'b1) begin errors++; $display("FAIL b2b_wdone got=%b exp=1", hready); end
    next_cycle();
    htrans = 2'b00;
    #1;
    checks++; if (hready !== 1'b1 || hrdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_read got=%b/%h exp=1/22222222", hready, hrdata); end
  endtask

  task automatic test_unmapped();
    next_cycle();
    haddr = 32'h8000; htrans = 2'b10;
    #1;
    checks++; if (s_hsel !== 4'b0000 || s_htrans !== 8'h00) begin errors++; $display("FAIL miss_addr got=%b/%h exp=0000/00", s_hsel, s_htrans); end
    next_cycle();
    htrans = 2'b00;
    #1;
    checks++; if (hready !== 1'b0 || hresp !== 1'b1 || hrdata !== 32'h0) begin errors++; $display("FAIL miss_err1 got=%b/%b/%h exp=0/1/0", hready, hresp, hrdata); end
    next_cycle();
    haddr = 32'h9000; htrans = 2'b10;
    #1;
    checks++; if (hready !== 1'b1 || hresp !== 1'b1 || s_htrans !== 8'h00) begin errors++; $display("FAIL miss_err2 got=%b/%b/%h exp=1/1/00", hready, hresp, s_htrans); end
    next_cycle();
    htrans = 2'b00;
    #1;
    checks++; if (hready !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL miss_again_err1 got=%b/%b exp=0/1", hready, hresp); end
    next_cycle();
    checks++; if (hready !== 1'b1 || hresp !== 1'b1) begin errors++; $display("FAIL miss_again_err2 got=%b/%b exp=1/1", hready, hresp); end
    next_cycle();
    checks++; if (hready !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL miss_okay got=%b/%b exp=1/0", hready, hresp); end
  endtask

  task automatic test_busy();
    s_hrdata[3*DW +: DW] = 32'h3333_3333;
    haddr = 32'h3000; htrans = 2'b10; hburst = 3'b001;
    next_cycle();
    haddr = 32'h3004; htrans = 2'b01;
    #1;
    checks++; if (s_htrans[7:6] !== 2'b01) begin errors++; $display("FAIL busy_fwd got=%b exp=01", s_htrans[7:6]); end
    checks++; if (hrdata !== 32'h3333_3333) begin errors++; $display("FAIL busy_data got=%h exp=33333333", hrdata); end
    next_cycle();
    htrans = 2'b00; s_hready_i[3] = 1'b0;
    #1;
    checks++; if (hready !== 1'b1 || hrdata !== 32'h0) begin errors++; $display("FAIL busy_none got=%b/%h exp=1/0", hready, hrdata); end
    s_hready_i[3] = 1'b1; hburst = 3'b000;
  endtask

  task automatic test_overlap();
    next_cycle();
    haddr = 32'h1008; htrans = 2'b10;
    #1;
    checks++; if (o2_hsel !== 4'b0010) begin errors++; $display("FAIL overlap_hsel got=%b exp=0010", o2_hsel); end
    checks++; if (o2_htrans !== 8'h08) begin errors++; $display("FAIL overlap_htrans got=%h exp=08", o2_htrans); end
    next_cycle();
    htrans = 2'b00;
  endtask

  task automatic test_reset_mid();
    next_cycle();
    haddr = 32'h3000; htrans = 2'b10;
    next_cycle();
    htrans = 2'b00; s_hready_i[3] = 1'b0;
    #1;
    checks++; if (hready !== 1'b0) begin errors++; $display("FAIL rmid_stall got=%b exp=0", hready); end
    rst = 1'b1;
    #1;
    checks++; if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin errors++; $display("FAIL rmid_async got=%b/%b/%h exp=1/0/0", hready, hresp, hrdata); end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (hready !== 1'b1) begin errors++; $display("FAIL rmid_release got=%b exp=1", hready); end
    haddr = 32'h1000; htrans = 2'b10;
    #1;
    checks++; if (s_hsel !== 4'b0010) begin errors++; $display("FAIL rmid_decode got=%b exp=0010", s_hsel); end
    next_cycle();
    htrans = 2'b00;
    #1;
    checks++; if (hrdata !== 32'hDEAD_BEEF || hready !== 1'b1) begin errors++; $display("FAIL rmid_read got=%b/%h exp=1/deadbeef", hready, hrdata); end
    s_hready_i[3] = 1'b1;
  endtask

  task automatic test_timeout();
    next_cycle();
    haddr = 32'h0000; htrans = 2'b10;
    next_cycle();
    htrans = 2'b00; s_hready_i[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (hready !== 1'b0 || hresp !== 1'b0) begin errors++; $display("FAIL tmo_stall%0d got=%b/%b exp=0/0", i, hready, hresp); end
      next_cycle();
    end
`ifdef AHB_TIMEOUT_EN
    checks++; if (hready !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL tmo_err1 got=%b/%b exp=0/1", hready, hresp); end
    next_cycle();
    checks++; if (hready !== 1'b1 || hresp !== 1'b1 || tflag !== 1'b1) begin errors++; $display("FAIL tmo_err2 got=%b/%b/%b exp=1/1/1", hready, hresp, tflag); end
    next_cycle();
    checks++; if (hready !== 1'b1 || hresp !== 1'b0 || tflag !== 1'b1) begin errors++; $display("FAIL tmo_after got=%b/%b/%b exp=1/0/1", hready, hresp, tflag); end
`else
    for (int i = 0; i < 4; i++) begin
      checks++; if (hready !== 1'b0 || tflag !== 1'b0) begin errors++; $display("FAIL tmo_hold%0d got=%b/%b exp=0/0", i, hready, tflag); end
      next_cycle();
    end
`endif
    s_hready_i[0] = 1'b1;
    next_cycle();
    rst = 1'b1;
    #1;
    checks++; if (tflag !== 1'b0) begin errors++; $display("FAIL tmo_rst_flag got=%b exp=0", tflag); end
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_unmapped();
    test_busy();
    test_overlap();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_lite_interconnect.md
AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, HWDATA/HRDATA width (32 or 64).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, HADDR width.
REQ-004 SHALL have parameter SLAVE_BASE_ADDR, default {0x3000,0x2000,0x1000,0x0000}, flattened NUM_SLAVES×ADDR_WIDTH, slave i at bits [i*ADDR_WIDTH+:ADDR_WIDTH].
REQ-005 SHALL have parameter SLAVE_ADDR_MASK, default 0xFFFF_F000 per slave, flattened like SLAVE_BASE_ADDR.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16, slave-stall limit (2..65535).
REQ-007 Ports: clk in 1 clock; rst in 1 async active-high reset.
REQ-008 Master side: m_haddr_in in ADDR_WIDTH; m_hwdata_in in DATA_WIDTH; m_htrans_in in 2; m_hsize_in in 3; m_hburst_in in 3; m_hprot_in in 4; m_hwrite_in in 1; m_hmastlock_in in 1; m_hrdata_out out DATA_WIDTH; m_hready_out out 1; m_hresp_out out 1.
REQ-009 Slave side (flattened, slave i at slice i): s_haddr_out out N×ADDR_WIDTH; s_hwdata_out out N×DATA_WIDTH; s_hrdata_in in N×DATA_WIDTH; s_htrans_out out N×2; s_hsize_out out N×3; s_hburst_out out N×3; s_hprot_out out N×4; s_hwrite_out out N; s_hmastlock_out out N; s_hsel_out out N; s_hready_out out N; s_hready_in in N; s_hresp_in in N.
REQ-010 timeout_flag out 1: sticky slave-timeout indicator.

Function
REQ-011 Address decode SHALL be combinational: slave i hits when (m_haddr_in & MASK[i]) == BASE[i]; on overlap, lowest index wins; s_hsel_out is one-hot or zero.
REQ-012 s_haddr/hwdata/hsize/hburst/hprot/hwrite/hmastlock SHALL broadcast master values to all slaves (never X).
REQ-013 s_htrans_out[i] SHALL equal m_htrans_in when s_hsel_out[i]=1, else IDLE (2'b00).
REQ-014 s_hready_out[i] SHALL equal m_hready_out for all i.
REQ-015 Data-phase owner register dsel SHALL update only on clk rising edge with m_hready_out=1: NONSEQ/SEQ with hit -> that slave; NONSEQ/SEQ with miss -> DEFAULT; IDLE/BUSY -> NONE.
REQ-016 dsel=slave k: m_hready_out=s_hready_in[k], m_hresp_out=s_hresp_in[k], m_hrdata_out=s_hrdata_in slice k.
REQ-017 dsel=NONE: m_hready_out=1, m_hresp_out=0, m_hrdata_out=0 (zero-wait OKAY).
REQ-018 Default-slave FSM states DS_IDLE, DS_ERR1, DS_ERR2; DS_IDLE->DS_ERR1 when dsel loads DEFAULT; DS_ERR1 drives hready=0, hresp=1, always ->DS_ERR2; DS_ERR2 drives hready=1, hresp=1, ->DS_IDLE unless another miss is accepted that cycle (then ->DS_ERR1).
REQ-019 During DS_ERR1/ERR2, m_hrdata_out SHALL be 0; address-phase decode continues per REQ-011/013.
REQ-020 Back-to-back transfers to different slaves SHALL incur zero added wait states; the only latency source is the data-phase slave.
REQ-021 Master BUSY inside a burst SHALL be forwarded as BUSY to the selected slave and SHALL load dsel=NONE.

Reset
REQ-022 rst=1 SHALL asynchronously force dsel=NONE, FSM=DS_IDLE, timeout counter=0, timeout_flag=0.
REQ-023 During and immediately after reset, m_hready_out=1, m_hresp_out=0, m_hrdata_out=0; a transfer in flight at reset is abandoned with no response.

Configuration
REQ-024 Macro AHB_TIMEOUT_EN: when defined, a 16-bit counter SHALL increment each cycle dsel=slave k with s_hready_in[k]=0, clear on s_hready_in[k]=1 or dsel change.
REQ-025 With AHB_TIMEOUT_EN, counter reaching TIMEOUT_CYCLES SHALL force the REQ-018 two-cycle ERROR to the master (ignoring slave k), set timeout_flag until rst, then release dsel per REQ-015.
REQ-026 Without AHB_TIMEOUT_EN, no counter logic SHALL exist, timeout_flag SHALL be constant 0, and slave stalls propagate indefinitely.

Verification
REQ-027 Read NONSEQ 0x1004, slave1 hready=1 rdata=0xDEADBEEF -> s_hsel_out=4'b0010 in address phase; next cycle m_hrdata_out=0xDEADBEEF, hresp=0.
REQ-028 Write 0x0010 then read 0x2020 back-to-back, slave0 inserts 2 wait states -> m_hready_out low 2 cycles, read data phase from slave2 immediately follows with no extra wait.
REQ-029 NONSEQ to 0x8000 (unmapped) -> m_hready_out=0/m_hresp_out=1, then 1/1, then OKAY; all s_htrans_out IDLE throughout.
REQ-030 Overlap: BASE[1]=BASE[2]=0x1000, access 0x1008 -> only s_hsel_out[1] asserted.
REQ-031 rst asserted during slave3 wait state -> outputs immediately hready=1, hresp=0, rdata=0; next transfer after release decodes normally.
REQ-032 AHB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave0 holds hready=0 -> 16 stall cycles then two-cycle ERROR, timeout_flag=1 until reset; without macro, stall persists and timeout_flag=0.
